// File: rtl/id_ctrl_stage_if.sv
// ID/EX decode-stage bus: IF/ID-side instruction handshake plus the registered control bundle.
// master drives the instruction side, slave is the decode stage.
interface id_ctrl_stage_if #(
  parameter int ALUOP_W = 3,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 16
);
  logic [31:0]        instr_i;
  logic               instr_valid_i;
  logic               id_ready_o;
  logic               flush_i;
  logic               ex_ready_i;
  logic               ex_valid_o;
  logic               RegWrite_o;
  logic               ALUSrc_o;
  logic               Branch_o;
  logic               sign_o;
  logic               Jump_o;
  logic               MemRead_o;
  logic               MemWrite_o;
  logic [ALUOP_W-1:0] ALU_op_o;
  logic [1:0]         RegDst_o;
  logic [1:0]         BranchType_o;
  logic [1:0]         MemtoReg_o;
  logic [REG_AW-1:0]  ex_rs_o;
  logic [REG_AW-1:0]  ex_rt_o;
  logic [REG_AW-1:0]  ex_rd_o;
  logic               illegal_o;
  logic [CNT_W-1:0]   stall_cnt_o;

  modport master (
    output instr_i, instr_valid_i, flush_i, ex_ready_i,
    input  id_ready_o, ex_valid_o, RegWrite_o, ALUSrc_o, Branch_o, sign_o, Jump_o,
           MemRead_o, MemWrite_o, ALU_op_o, RegDst_o, BranchType_o, MemtoReg_o,
           ex_rs_o, ex_rt_o, ex_rd_o, illegal_o, stall_cnt_o
  );

  modport slave (
    input  instr_i, instr_valid_i, flush_i, ex_ready_i,
    output id_ready_o, ex_valid_o, RegWrite_o, ALUSrc_o, Branch_o, sign_o, Jump_o,
           MemRead_o, MemWrite_o, ALU_op_o, RegDst_o, BranchType_o, MemtoReg_o,
           ex_rs_o, ex_rt_o, ex_rd_o, illegal_o, stall_cnt_o
  );
endinterface

// File: rtl/id_ctrl_stage.sv
// Pipelined MIPS main decoder with load-use bubble, branch flush and stall counter.
// Optional macro ID_JR_DECODE_EN: decode R-type jr as a jump that reads rs only.
module id_ctrl_stage #(
  parameter int ALUOP_W = 3,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  id_ctrl_stage_if.slave bus
);
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
`ifdef ID_JR_DECODE_EN
  localparam logic [5:0] FN_JR     = 6'b001000;
`endif

  // w_ctl packing: {RegWrite, ALU_op[2:0], RegDst[1:0], Branch, sign, BranchType[1:0],
  //                 Jump, MemRead, MemWrite, MemtoReg[1:0]}
  logic [5:0]        w_op, w_fn;
  logic [REG_AW-1:0] w_rs, w_rt, w_rd;
  logic [14:0]       w_ctl;
  logic              w_illegal, w_uses_rt, w_alusrc;
  logic              w_load, w_hazard;
  logic              w_unused_bits;

  logic              r_valid;
  logic [14:0]       r_ctl;
  logic              r_alusrc, r_illegal;
  logic [REG_AW-1:0] r_rs, r_rt, r_rd;
  logic [CNT_W-1:0]  r_cnt;

  assign w_op          = bus.instr_i[31:26];
  assign w_fn          = bus.instr_i[5:0];
  assign w_rs          = REG_AW'(bus.instr_i[25:21]);
  assign w_rt          = REG_AW'(bus.instr_i[20:16]);
  assign w_rd          = REG_AW'(bus.instr_i[15:11]);
  assign w_alusrc      = w_op[3] | w_op[5];
  assign w_unused_bits = ^{bus.instr_i[10:6], w_fn};

  always_comb begin
    w_ctl     = 15'b0_000_01_0_1_00_0_0_0_00;
    w_illegal = 1'b0;
    w_uses_rt = 1'b0;
    case (w_op)
      OP_JAL:          w_ctl = 15'b1_011_10_0_1_00_1_0_0_11;
      OP_LW:           w_ctl = 15'b1_110_00_0_1_00_0_1_0_01;
      OP_SW:    begin  w_ctl = 15'b0_110_00_0_1_00_0_0_1_00; w_uses_rt = 1'b1; end
      OP_J:            w_ctl = 15'b0_011_01_0_1_00_1_0_0_00;
      OP_BEQ:   begin  w_ctl = 15'b0_011_00_1_1_00_0_0_0_00; w_uses_rt = 1'b1; end
      OP_REGIMM:       w_ctl = 15'b0_011_00_1_1_10_0_0_0_00;
      OP_BNE:   begin  w_ctl = 15'b0_011_00_1_1_11_0_0_0_00; w_uses_rt = 1'b1; end
      OP_BGTZ:  begin  w_ctl = 15'b0_011_00_1_1_01_0_0_0_00; w_uses_rt = 1'b1; end
      OP_ADDI,
      OP_LUI:          w_ctl = 15'b1_110_00_0_1_00_0_0_0_00;
      OP_ORI:          w_ctl = 15'b1_101_00_0_0_00_0_0_0_00;
      OP_RTYPE: begin
        w_ctl     = 15'b1_000_01_0_1_00_0_0_0_00;
        w_uses_rt = 1'b1;
`ifdef ID_JR_DECODE_EN
        if (w_fn == FN_JR) begin
          w_ctl     = 15'b0_000_00_0_1_00_1_0_0_00;
          w_uses_rt = 1'b0;
        end
`endif
      end
      default:         w_illegal = 1'b1;
    endcase
  end

  // Handshake: the instruction on instr_i is consumed at a rising edge only when
  // instr_valid_i & id_ready_o; the registered bundle leaves at an edge when
  // ex_valid_o & ex_ready_i, and a held bundle never changes while ex_ready_i is low.
  assign w_load   = !r_valid | bus.ex_ready_i;
  assign w_hazard = bus.instr_valid_i & r_valid & r_ctl[3] & (r_rt != '0) &
                    ((r_rt == w_rs) | (w_uses_rt & (r_rt == w_rt)));
  assign bus.id_ready_o = w_load & (bus.flush_i | !w_hazard);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid   <= 1'b0;
      r_ctl     <= '0;
      r_alusrc  <= 1'b0;
      r_illegal <= 1'b0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
    end else if (w_load) begin
      if (bus.flush_i || w_hazard || !bus.instr_valid_i) begin
        // Bubble: all-zero bundle so EX sees no write side effects.
        r_valid   <= 1'b0;
        r_ctl     <= '0;
        r_alusrc  <= 1'b0;
        r_illegal <= 1'b0;
        r_rs      <= '0;
        r_rt      <= '0;
        r_rd      <= '0;
        if (!bus.flush_i && w_hazard && (r_cnt != '1))
          r_cnt <= r_cnt + 1'b1;
      end else begin
        r_valid   <= 1'b1;
        r_ctl     <= w_ctl;
        r_alusrc  <= w_alusrc;
        r_illegal <= w_illegal;
        r_rs      <= w_rs;
        r_rt      <= w_rt;
        r_rd      <= w_rd;
      end
    end
  end

  assign bus.ex_valid_o   = r_valid;
  assign bus.RegWrite_o   = r_ctl[14];
  assign bus.ALU_op_o     = ALUOP_W'(r_ctl[13:11]);
  assign bus.RegDst_o     = r_ctl[10:9];
  assign bus.Branch_o     = r_ctl[8];
  assign bus.sign_o       = r_ctl[7];
  assign bus.BranchType_o = r_ctl[6:5];
  assign bus.Jump_o       = r_ctl[4];
  assign bus.MemRead_o    = r_ctl[3];
  assign bus.MemWrite_o   = r_ctl[2];
  assign bus.MemtoReg_o   = r_ctl[1:0];
  assign bus.ALUSrc_o     = r_alusrc;
  assign bus.illegal_o    = r_illegal;
  assign bus.ex_rs_o      = r_rs;
  assign bus.ex_rt_o      = r_rt;
  assign bus.ex_rd_o      = r_rd;
  assign bus.stall_cnt_o  = r_cnt;
endmodule

// File: tb/tb_id_ctrl_stage.sv
// Directed bench for id_ctrl_stage: a table-level decode/hazard model feeds an expected
// queue that is compared against the DUT every cycle, plus hand-computed spot checks.
module tb_id_ctrl_stage;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;

  id_ctrl_stage_if bus ();
  id_ctrl_stage dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct packed {
    logic       rw;
    logic [2:0] alu;
    logic [1:0] rdsel;
    logic       br;
    logic       sgn;
    logic [1:0] bt;
    logic       jmp;
    logic       mr;
    logic       mw;
    logic [1:0] mtr;
    logic       alusrc;
    logic       ill;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } bund_t;

  // ---------------- instruction builders ----------------
  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  // ---------------- behavioural model ----------------
  function automatic logic is_jr(logic [31:0] ins);
`ifdef ID_JR_DECODE_EN
    return (ins[31:26] == 6'b000000) && (ins[5:0] == 6'b001000);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bund_t model_decode(logic [31:0] ins);
    bund_t b;
    logic [5:0] op;
    op = ins[31:26];
    b = '0;
    b.rs = ins[25:21];
    b.rt = ins[20:16];
    b.rd = ins[15:11];
    b.alusrc = op[3] | op[5];
    case (op)
      6'b100011: begin b.rw = 1; b.alu = 6; b.sgn = 1; b.mr = 1; b.mtr = 1; end        // lw
      6'b101011: begin b.alu = 6; b.sgn = 1; b.mw = 1; end                            // sw
      6'b000011: begin b.rw = 1; b.alu = 3; b.rdsel = 2; b.sgn = 1; b.jmp = 1; b.mtr = 3; end // jal
      6'b000010: begin b.alu = 3; b.rdsel = 1; b.sgn = 1; b.jmp = 1; end              // j
      6'b000100: begin b.alu = 3; b.br = 1; b.sgn = 1; b.bt = 0; end                  // beq
      6'b000001: begin b.alu = 3; b.br = 1; b.sgn = 1; b.bt = 2; end                  // bgez
      6'b000101: begin b.alu = 3; b.br = 1; b.sgn = 1; b.bt = 3; end                  // bnez
      6'b000111: begin b.alu = 3; b.br = 1; b.sgn = 1; b.bt = 1; end                  // bgt
      6'b001000, 6'b001111: begin b.rw = 1; b.alu = 6; b.sgn = 1; end                 // addi, lui
      6'b001101: begin b.rw = 1; b.alu = 5; end                                       // ori
      6'b000000: begin
        if (is_jr(ins)) begin b.sgn = 1; b.jmp = 1; end
        else begin b.rw = 1; b.rdsel = 1; b.sgn = 1; end
      end
      default: begin b.rdsel = 1; b.sgn = 1; b.ill = 1; end
    endcase
    return b;
  endfunction

  function automatic logic model_uses_rt(logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (is_jr(ins)) return 1'b0;
    return (op == 6'b000000) || (op == 6'b101011) || (op == 6'b000100) ||
           (op == 6'b000101) || (op == 6'b000111);
  endfunction

  logic  m_valid = 1'b0;
  bund_t m_b = '0;
  int    m_cnt = 0;

  function automatic logic model_hazard();
    if (!(bus.instr_valid_i && m_valid && m_b.mr && m_b.rt != 0)) return 1'b0;
    if (m_b.rt == bus.instr_i[25:21]) return 1'b1;
    return model_uses_rt(bus.instr_i) && (m_b.rt == bus.instr_i[20:16]);
  endfunction

  function automatic logic model_ready();
    return (!m_valid || bus.ex_ready_i) && (bus.flush_i || !model_hazard());
  endfunction

  // ---------------- scoreboard ----------------
  logic [48:0] exp_q[$];   // {ex_valid, bundle, stall_cnt}

  always @(posedge clk) begin
    logic hz;
    hz = model_hazard();
    if (rst) begin
      m_valid = 0; m_b = '0; m_cnt = 0;
    end else if (!m_valid || bus.ex_ready_i) begin
      if (bus.flush_i) begin
        m_valid = 0; m_b = '0;
      end else if (hz) begin
        m_valid = 0; m_b = '0;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end else begin
        m_valid = bus.instr_valid_i;
        m_b = bus.instr_valid_i ? model_decode(bus.instr_i) : '0;
      end
    end
    exp_q.push_back({m_valid, m_b, 16'(m_cnt)});
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bund_t dut_bund();
    return {bus.RegWrite_o, bus.ALU_op_o, bus.RegDst_o, bus.Branch_o, bus.sign_o,
            bus.BranchType_o, bus.Jump_o, bus.MemRead_o, bus.MemWrite_o, bus.MemtoReg_o,
            bus.ALUSrc_o, bus.illegal_o, bus.ex_rs_o, bus.ex_rt_o, bus.ex_rd_o};
  endfunction

  always @(negedge clk) begin
    logic [48:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cyc_ex_valid", 32'(bus.ex_valid_o), 32'(e[48]));
      check("cyc_bundle", dut_bund(), e[47:16]);
      check("cyc_stall_cnt", 32'(bus.stall_cnt_o), 32'(e[15:0]));
      check("cyc_id_ready", 32'(bus.id_ready_o), 32'(model_ready()));
    end
  end

  // ---------------- drivers ----------------
  task automatic set_in(logic [31:0] ins, logic v, logic fl, logic er);
    bus.instr_i       = ins;
    bus.instr_valid_i = v;
    bus.flush_i       = fl;
    bus.ex_ready_i    = er;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  logic [31:0] LW_T0, ADD_U8, ORI_A, ORI_B, JR9;
  logic [31:0] misc [10];

  initial begin
    LW_T0  = itype(6'b100011, 5'd9, 5'd8, 16'h0004);
    ADD_U8 = rtype(5'd8, 5'd10, 5'd11, 6'b100000);
    ORI_A  = itype(6'b001101, 5'd1, 5'd5, 16'h00ff);
    ORI_B  = itype(6'b001101, 5'd2, 5'd6, 16'h0f0f);
    JR9    = rtype(5'd9, 5'd8, 5'd0, 6'b001000);
    misc[0] = itype(6'b000011, 5'd0, 5'd0, 16'h0010);  // jal
    misc[1] = itype(6'b000010, 5'd0, 5'd0, 16'h0020);  // j
    misc[2] = itype(6'b101011, 5'd3, 5'd4, 16'h0008);  // sw
    misc[3] = itype(6'b001000, 5'd3, 5'd7, 16'hfff0);  // addi
    misc[4] = itype(6'b001111, 5'd0, 5'd7, 16'h1234);  // lui
    misc[5] = itype(6'b000001, 5'd3, 5'd1, 16'h0004);  // bgez
    misc[6] = itype(6'b000101, 5'd3, 5'd0, 16'h0004);  // bnez
    misc[7] = itype(6'b000111, 5'd3, 5'd0, 16'h0004);  // bgt
    misc[8] = itype(6'b100011, 5'd3, 5'd12, 16'h0000); // lw
    misc[9] = rtype(5'd12, 5'd13, 5'd14, 6'b100010);   // sub, load-use on rs

    rst = 1'b1;
    set_in(LW_T0, 1, 0, 1);
    tick(); tick();
    check("rst_ex_valid", 32'(bus.ex_valid_o), 0);
    check("rst_bundle", dut_bund(), 0);
    check("rst_stall_cnt", 32'(bus.stall_cnt_o), 0);
    check("rst_id_ready", 32'(bus.id_ready_o), 1);
    rst = 1'b0;

    // lw rt=8 then add rs=8: one bubble
    set_in(LW_T0, 1, 0, 1); tick();
    check("lw_regwrite", 32'(bus.RegWrite_o), 1);
    check("lw_memread", 32'(bus.MemRead_o), 1);
    check("lw_memtoreg", 32'(bus.MemtoReg_o), 1);
    check("lw_aluop", 32'(bus.ALU_op_o), 6);
    check("lw_alusrc", 32'(bus.ALUSrc_o), 1);
    set_in(ADD_U8, 1, 0, 1); #1;
    check("hz_ready_low", 32'(bus.id_ready_o), 0);
    tick();
    check("hz_bubble_valid", 32'(bus.ex_valid_o), 0);
    check("hz_bubble_regwrite", 32'(bus.RegWrite_o), 0);
    check("hz_stall_cnt", 32'(bus.stall_cnt_o), 1);
    #1 check("hz_ready_after", 32'(bus.id_ready_o), 1);
    tick();
    check("add_valid", 32'(bus.ex_valid_o), 1);
    check("add_regdst", 32'(bus.RegDst_o), 1);
    check("add_rd", 32'(bus.ex_rd_o), 11);

    // lw rt=0 then add rs=0: no bubble
    set_in(itype(6'b100011, 5'd9, 5'd0, 16'h0), 1, 0, 1); tick();
    set_in(rtype(5'd0, 5'd0, 5'd3, 6'b100000), 1, 0, 1); #1;
    check("rt0_ready", 32'(bus.id_ready_o), 1);
    tick();
    check("rt0_stall_cnt", 32'(bus.stall_cnt_o), 1);

    // flush wins over hazard and does not count
    set_in(LW_T0, 1, 0, 1); tick();
    set_in(ADD_U8, 1, 1, 1); #1;
    check("flush_hz_ready", 32'(bus.id_ready_o), 1);
    tick();
    check("flush_hz_cnt", 32'(bus.stall_cnt_o), 1);

    // beq flushed
    set_in(itype(6'b000100, 5'd1, 5'd2, 16'h0003), 1, 1, 1); #1;
    check("beq_flush_ready", 32'(bus.id_ready_o), 1);
    tick();
    check("beq_flush_valid", 32'(bus.ex_valid_o), 0);
    check("beq_flush_bundle", dut_bund(), 0);

    // EX back-pressure holds ori, flush ignored meanwhile
    set_in(ORI_A, 1, 0, 1); tick();
    check("ori_aluop", 32'(bus.ALU_op_o), 5);
    set_in(ORI_B, 1, 0, 0); #1;
    check("bp_ready_low", 32'(bus.id_ready_o), 0);
    tick();
    set_in(ORI_B, 1, 1, 0); tick();
    set_in(ORI_B, 1, 0, 0); tick();
    check("bp_hold_rt", 32'(bus.ex_rt_o), 5);
    check("bp_hold_valid", 32'(bus.ex_valid_o), 1);
    set_in(ORI_B, 1, 0, 1); tick();
    check("bp_release_rt", 32'(bus.ex_rt_o), 6);

    // illegal opcode
    set_in({6'b111111, 26'h0123456}, 1, 0, 1); tick();
    check("ill_flag", 32'(bus.illegal_o), 1);
    check("ill_regwrite", 32'(bus.RegWrite_o), 0);

    // jr decode
    set_in(JR9, 1, 0, 1); tick();
`ifdef ID_JR_DECODE_EN
    check("jr_jump", 32'(bus.Jump_o), 1);
    check("jr_regwrite", 32'(bus.RegWrite_o), 0);
`else
    check("jr_jump", 32'(bus.Jump_o), 0);
    check("jr_regwrite", 32'(bus.RegWrite_o), 1);
`endif

    // lw -> lw -> use: one bubble each
    set_in(itype(6'b100011, 5'd1, 5'd8, 16'h0), 1, 0, 1); tick();
    set_in(itype(6'b100011, 5'd8, 5'd9, 16'h0), 1, 0, 1); tick(); tick();
    set_in(rtype(5'd9, 5'd2, 5'd4, 6'b100000), 1, 0, 1); tick(); tick();
    check("b2b_stall_cnt", 32'(bus.stall_cnt_o), 3);

    // sw uses rt -> bubble; ori does not -> none
    set_in(LW_T0, 1, 0, 1); tick();
    set_in(itype(6'b101011, 5'd1, 5'd8, 16'h0), 1, 0, 1); tick(); tick();
    check("sw_rt_stall_cnt", 32'(bus.stall_cnt_o), 4);
    set_in(LW_T0, 1, 0, 1); tick();
    set_in(itype(6'b001101, 5'd1, 5'd8, 16'h0), 1, 0, 1); tick();
    check("ori_rt_stall_cnt", 32'(bus.stall_cnt_o), 4);

    // jr after lw whose rt matches jr's rt field
    set_in(LW_T0, 1, 0, 1); tick();
    set_in(JR9, 1, 0, 1); tick(); tick();

    // remaining decode rows with intermittent back-pressure and idle slots
    for (int i = 0; i < 10; i++) begin
      set_in(misc[i], 1, 0, (i % 3) != 2);
      tick();
      if (i == 4) begin
        set_in(32'h0, 0, 0, 1); tick();
      end
    end
    set_in(misc[9], 1, 0, 1); tick();
    set_in(32'h0, 0, 0, 1); tick(); tick();
    check("idle_valid", 32'(bus.ex_valid_o), 0);

    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
